// File: rtl/flopr.sv
// Parameterized pipeline register with asynchronous active-high clear.
// Sits on every stage boundary; field layout belongs to the caller.
module flopr #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1) begin : g_width_chk
    $error("flopr: WIDTH=%0d is illegal, must be >= 1", WIDTH);
  end

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_flopr.sv
// Directed bench for flopr: default, non-zero reset,
// 108-bit and 1-bit instances sharing clock and reset.
module tb_flopr;

  logic         clk;
  logic         reset;
  logic [7:0]   d8;
  logic [7:0]   q8;
  logic [7:0]   drv;
  logic [7:0]   qrv;
  logic [107:0] dw;
  logic [107:0] qw;
  logic [0:0]   d1;
  logic [0:0]   q1;

  int total;
  int bad;

  flopr u_d8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  flopr #(
    .WIDTH       (8),
    .RESET_VALUE (8'h13)
  ) u_rv (
    .clk   (clk),
    .reset (reset),
    .d     (drv),
    .q     (qrv)
  );

  flopr #(
    .WIDTH (108)
  ) u_wide (
    .clk   (clk),
    .reset (reset),
    .d     (dw),
    .q     (qw)
  );

  flopr #(
    .WIDTH (1)
  ) u_w1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [107:0] obs,
    input logic [107:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [107:0] one;
    logic [7:0]   prev;
    total = 0;
    bad   = 0;
    one   = 108'd1;
    reset = 1'b1;
    d8    = 8'h00;
    drv   = 8'h00;
    dw    = '0;
    d1    = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_q8", 108'(q8), 108'h00);
    chk("rst_rv", 108'(qrv), 108'h13);
    chk("rst_wide", qw, '0);
    chk("rst_w1", 108'(q1), 108'h0);

    // Release, then load
    reset = 1'b0;
    d8    = 8'hA5;
    drv   = 8'h42;
    tick();
    chk("load_a5", 108'(q8), 108'hA5);
    chk("rv_load", 108'(qrv), 108'h42);
    d8 = 8'h3C;
    tick();
    chk("load_3c", 108'(q8), 108'h3C);

    // Asynchronous clear between edges
    d8 = 8'hFF;
    tick();
    chk("load_ff", 108'(q8), 108'hFF);
    #4;
    reset = 1'b1;
    #1;
    chk("async_clr", 108'(q8), 108'h00);
    chk("async_rv", 108'(qrv), 108'h13);
    d8 = 8'h55;
    tick();
    chk("hold_rst", 108'(q8), 108'h00);

    // Reset released on the clock edge itself
    d8 = 8'h77;
    @(posedge clk);
    reset <= 1'b0;
    #1;
    chk("coinc_edge", 108'(q8), 108'h00);
    tick();
    chk("coinc_next", 108'(q8), 108'h77);

    // Walking one across 108 bits
    for (int i = 0; i < 108; i++) begin
      dw = one << i;
      tick();
      chk($sformatf("walk%0d", i), qw, one << i);
    end
    dw = '1;
    tick();
    chk("wide_ones", qw, {108{1'b1}});
    #4;
    reset = 1'b1;
    #1;
    chk("wide_clr", qw, '0);
    tick();
    reset = 1'b0;

    // Single-bit instance
    d1 = 1'b0;
    tick();
    chk("w1_0a", 108'(q1), 108'h0);
    d1 = 1'b1;
    tick();
    chk("w1_1", 108'(q1), 108'h1);
    d1 = 1'b0;
    tick();
    chk("w1_0b", 108'(q1), 108'h0);

    // Streaming: one-cycle lag, no skips
    prev = q8;
    for (int i = 0; i < 256; i++) begin
      d8 = 8'(i);
      #3;
      chk($sformatf("lag%0d", i), 108'(q8), 108'(prev));
      tick();
      chk($sformatf("strm%0d", i), 108'(q8), 108'(i));
      prev = 8'(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
